multicycle_sequencer: RTL



---
 rtl/proc_pkg.sv | 58 +++++
 rtl/opcode_decode.sv | 22 ++
 rtl/multicycle_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the multicycle ARMv8 control sequencer: FSM states,
// instruction classes, opcode match patterns and ALU / sign-extender codes.
package proc_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;

  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_ADD     = 4'd1,
    CLS_SUB     = 4'd2,
    CLS_AND     = 4'd3,
    CLS_ORR     = 4'd4,
    CLS_LDUR    = 4'd5,
    CLS_STUR    = 4'd6,
    CLS_CBZ     = 4'd7,
    CLS_B       = 4'd8,
    CLS_MOVZ    = 4'd9
  } cls_e;

  // Opcode patterns: a bit takes part in the match only where its mask bit is 1.
  localparam logic [10:0] OP_ADD    = 11'b10001011000;
  localparam logic [10:0] OP_SUB    = 11'b11001011000;
  localparam logic [10:0] OP_AND    = 11'b10001010000;
  localparam logic [10:0] OP_ORR    = 11'b10101010000;
  localparam logic [10:0] OP_LDUR   = 11'b11111000010;
  localparam logic [10:0] OP_STUR   = 11'b11111000000;
  localparam logic [10:0] OP_CBZ    = 11'b10110100000;
  localparam logic [10:0] OP_B      = 11'b00010100000;
  localparam logic [10:0] OP_MOVZ   = 11'b11010010100;
  localparam logic [10:0] MASK_FULL = 11'b11111111111;
  localparam logic [10:0] MASK_CBZ  = 11'b11111111000;
  localparam logic [10:0] MASK_B    = 11'b11111100000;
  localparam logic [10:0] MASK_MOVZ = 11'b11111111100;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  localparam logic [2:0] SE_D    = 3'b001;
  localparam logic [2:0] SE_B    = 3'b010;
  localparam logic [2:0] SE_CB   = 3'b011;
  localparam logic [2:0] SE_MOVZ = 3'b100;

  function automatic logic op_match(input logic [10:0] op,
                                    input logic [10:0] pat,
                                    input logic [10:0] mask);
    return ((op ^ pat) & mask) == 11'b0;
  endfunction

endpackage

// File: rtl/opcode_decode.sv
// Combinational classifier: instruction[31:21] -> instruction class.
module opcode_decode
  import proc_pkg::*;
(
  input  logic [10:0] opcode_i,
  output cls_e        cls_o
);

  always_comb begin
    cls_o = CLS_ILLEGAL;
    if      (op_match(opcode_i, OP_ADD,  MASK_FULL)) cls_o = CLS_ADD;
    else if (op_match(opcode_i, OP_SUB,  MASK_FULL)) cls_o = CLS_SUB;
    else if (op_match(opcode_i, OP_AND,  MASK_FULL)) cls_o = CLS_AND;
    else if (op_match(opcode_i, OP_ORR,  MASK_FULL)) cls_o = CLS_ORR;
    else if (op_match(opcode_i, OP_LDUR, MASK_FULL)) cls_o = CLS_LDUR;
    else if (op_match(opcode_i, OP_STUR, MASK_FULL)) cls_o = CLS_STUR;
    else if (op_match(opcode_i, OP_CBZ,  MASK_CBZ))  cls_o = CLS_CBZ;
    else if (op_match(opcode_i, OP_B,    MASK_B))    cls_o = CLS_B;
    else if (op_match(opcode_i, OP_MOVZ, MASK_MOVZ)) cls_o = CLS_MOVZ;
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM (FETCH/DECODE/EXEC/MEM/WB) with run/halt and a retire counter.
// Optional MEM_TIMEOUT_EN adds a MEM wait watchdog and the sticky memerr output.
module multicycle_sequencer
  import proc_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             run,
  input  logic [10:0]      opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             reg2loc,
  output logic             alusrc,
  output logic             mem2reg,
  output logic             regwrite,
  output logic             memread,
  output logic             memwrite,
  output logic             branch,
  output logic             uncond_branch,
  output logic [3:0]       aluop,
  output logic [2:0]       signop,
  output logic             busy,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count,
`ifdef MEM_TIMEOUT_EN
  output logic             memerr,
`endif
  output logic [2:0]       dbg_state
);

  logic [2:0]       state_q, state_d;
  cls_e             cls_q, cls_d, dec_cls, cur_cls;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic             wait_expire;

  // The branch condition is resolved in the datapath; the sequencer never needs zero.
  logic unused_zero;
  assign unused_zero = zero;

  opcode_decode u_dec (
    .opcode_i (opcode),
    .cls_o    (dec_cls)
  );

  // reg2loc must be valid in DECODE, before the class register is loaded.
  assign cur_cls = (state_q == ST_DECODE) ? dec_cls : cls_q;

`ifdef MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              memerr_q, memerr_d;

  always_comb begin
    wait_d      = wait_q;
    memerr_d    = memerr_q;
    wait_expire = 1'b0;
    if (state_q != ST_MEM) begin
      wait_d = '0;
    end else if (!mem_ready) begin
      wait_d = wait_q + WAIT_W'(1);
      if (wait_d == WAIT_W'(MEM_TIMEOUT)) begin
        wait_expire = 1'b1;
        memerr_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wait_q   <= '0;
      memerr_q <= 1'b0;
    end else begin
      wait_q   <= wait_d;
      memerr_q <= memerr_d;
    end
  end

  assign memerr = memerr_q;
`else
  localparam int unused_mem_timeout = MEM_TIMEOUT;
  assign wait_expire = 1'b0;
`endif

  always_comb begin
    retire = 1'b0;
    case (state_q)
      ST_EXEC: retire = (cls_q == CLS_CBZ) || (cls_q == CLS_B);
      ST_MEM:  retire = (cls_q == CLS_STUR) && mem_ready;
      ST_WB:   retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    illegal_d = illegal_q;
    cnt_d     = retire ? cnt_q + CNT_W'(1) : cnt_q;
    case (state_q)
      ST_IDLE:   if (run) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        cls_d = dec_cls;
        if (dec_cls == CLS_ILLEGAL) begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if ((cls_q == CLS_LDUR) || (cls_q == CLS_STUR)) state_d = ST_MEM;
        else                                            state_d = ST_WB;
      end
      ST_MEM:  if (mem_ready && (cls_q == CLS_LDUR)) state_d = ST_WB;
      ST_WB:   state_d = ST_WB;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    // run is only consulted in IDLE and here, so dropping it mid-instruction finishes that instruction.
    if (retire)      state_d = run ? ST_FETCH : ST_IDLE;
    if (wait_expire) state_d = ST_HALT;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cls_q     <= CLS_ILLEGAL;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    irwrite       = 1'b0;
    pcwrite       = 1'b0;
    reg2loc       = 1'b0;
    alusrc        = 1'b0;
    mem2reg       = 1'b0;
    regwrite      = 1'b0;
    memread       = 1'b0;
    memwrite      = 1'b0;
    branch        = 1'b0;
    uncond_branch = 1'b0;
    aluop         = '0;
    signop        = '0;
    if (state_q == ST_FETCH) irwrite = 1'b1;
    if ((state_q == ST_DECODE) || (state_q == ST_EXEC) ||
        (state_q == ST_MEM) || (state_q == ST_WB)) begin
      reg2loc = (cur_cls == CLS_STUR) || (cur_cls == CLS_CBZ);
    end
    // ALU and sign-extender controls stay stable from EXEC to the end of the instruction.
    if ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB)) begin
      case (cls_q)
        CLS_ADD:  aluop = ALU_ADD;
        CLS_SUB:  aluop = ALU_SUB;
        CLS_AND:  aluop = ALU_AND;
        CLS_ORR:  aluop = ALU_ORR;
        CLS_LDUR, CLS_STUR: begin
          aluop  = ALU_ADD;
          alusrc = 1'b1;
          signop = SE_D;
        end
        CLS_CBZ: begin
          aluop  = ALU_PASSB;
          signop = SE_CB;
        end
        CLS_B:    signop = SE_B;
        CLS_MOVZ: begin
          aluop  = ALU_PASSB;
          alusrc = 1'b1;
          signop = SE_MOVZ;
        end
        default: aluop = '0;
      endcase
    end
    case (state_q)
      ST_EXEC: begin
        branch        = (cls_q == CLS_CBZ);
        uncond_branch = (cls_q == CLS_B);
        pcwrite       = (cls_q == CLS_CBZ) || (cls_q == CLS_B);
      end
      ST_MEM: begin
        memread  = (cls_q == CLS_LDUR);
        memwrite = (cls_q == CLS_STUR);
        pcwrite  = (cls_q == CLS_STUR) && mem_ready;
      end
      ST_WB: begin
        regwrite = 1'b1;
        mem2reg  = (cls_q == CLS_LDUR);
        pcwrite  = 1'b1;
      end
      default: pcwrite = 1'b0;
    endcase
  end

  assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign instr_done  = retire;
  assign illegal     = illegal_q;
  assign instr_count = cnt_q;
  assign dbg_state   = state_q;

endmodule
